// File: rtl/pipeline_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding,
// bubble default and an occupancy helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // Replicated DATA_W times to form the default bubble payload.
  localparam logic BUBBLE_BIT = 1'b0;

  function automatic logic [1:0] state_occ(input state_e s);
    case (s)
      ST_HALF: state_occ = 2'd1;
      ST_FULL: state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_sat_counter.sv
// Saturating up-counter of discarded beats; adds 0..2 per cycle and sticks at
// its all-ones maximum.
module pipeline_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    if (sum > CNT_MAX) sat_add = CNT_MAX[CNT_W-1:0];
    else               sat_add = sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) cnt_p1 <= '0;
    else      cnt_p1 <= sat_add(cnt_p1, inc);
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline stage with a skid register: full throughput with every
// output registered, plus flush and a saturating discard count.
module pipeline_stage_skid
  import pipeline_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{BUBBLE_BIT}},
  parameter int                CNT_W      = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_p1, state_nxt;
  logic [DATA_W-1:0] main_p1, main_nxt;
  logic [DATA_W-1:0] skid_p1, skid_nxt;
  logic              vld_p1, rdy_p1;
  logic              accept, emit;
  logic [1:0]        discard;
  logic [1:0]        cnt_inc;

  assign accept = in_valid && rdy_p1;
  assign emit   = vld_p1 && out_ready;

  // Held beats minus the one delivered plus the one squashed; stays in 0..2.
  assign discard = state_occ(state_p1) - {1'b0, emit} + {1'b0, accept};
  assign cnt_inc = flush ? discard : 2'b00;

  always_comb begin
    state_nxt = state_p1;
    main_nxt  = main_p1;
    skid_nxt  = skid_p1;
    case (state_p1)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_HALF;
          main_nxt  = in_data;
        end
      end
      ST_HALF: begin
        if (accept && emit) begin
          main_nxt = in_data;
        end else if (accept) begin
          state_nxt = ST_FULL;
          skid_nxt  = in_data;
        end else if (emit) begin
          state_nxt = ST_EMPTY;
          main_nxt  = BUBBLE_VAL;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_nxt = ST_HALF;
          main_nxt  = skid_p1;
          skid_nxt  = BUBBLE_VAL;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        main_nxt  = BUBBLE_VAL;
        skid_nxt  = BUBBLE_VAL;
      end
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = BUBBLE_VAL;
      skid_nxt  = BUBBLE_VAL;
    end
  end

  // Stage register: ready/valid are precomputed from next state so every port is a flop.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_p1 <= ST_EMPTY;
      main_p1  <= BUBBLE_VAL;
      skid_p1  <= BUBBLE_VAL;
      vld_p1   <= 1'b0;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      main_p1  <= main_nxt;
      skid_p1  <= skid_nxt;
      vld_p1   <= (state_nxt != ST_EMPTY);
      rdy_p1   <= (state_nxt != ST_FULL);
    end
  end

  pipeline_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk(clk),
    .clr(clr),
    .inc(cnt_inc),
    .cnt(flush_cnt)
  );

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p1;
  assign out_data  = main_p1;
  assign occupancy = state_p1;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: directed vector table, counter-saturation
// sequence and randomized traffic against a queue-based reference model.
module tb_pipeline_stage_skid;

  localparam logic [31:0] BUB2 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        clr, in_valid, out_ready, flush;
  logic [31:0] in_data;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [1:0]  occ_a, occ_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .flush(flush), .occupancy(occ_a), .flush_cnt(cnt_a)
  );

  pipeline_stage_skid #(.DATA_W(32), .BUBBLE_VAL(BUB2), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .flush(flush), .occupancy(occ_b), .flush_cnt(cnt_b)
  );

  // Reference model: a FIFO of held beats plus the registered ready flag.
  logic [31:0] m_q[$];
  logic        m_rdy = 1'b1;
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic acc, em;
    int   inc;
    acc = in_valid && m_rdy;
    em  = (m_q.size() > 0) && out_ready;
    if (!clr) begin
      m_q.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_rdy  = 1'b1;
    end else if (flush) begin
      inc    = m_q.size() - int'(em) + int'(acc);
      m_cnt8 = (m_cnt8 + inc > 255) ? 255 : m_cnt8 + inc;
      m_cnt2 = (m_cnt2 + inc > 3) ? 3 : m_cnt2 + inc;
      m_q.delete();
      m_rdy  = 1'b1;
    end else begin
      if (em) void'(m_q.pop_front());
      if (acc) m_q.push_back(in_data);
      m_rdy = (m_q.size() < 2);
    end
  endtask

  task automatic check_model();
    logic        v;
    logic [31:0] f;
    v = (m_q.size() > 0);
    f = v ? m_q[0] : 32'h0;
    chk("mdl.out_valid", out_valid_a, v);
    chk("mdl.out_data", out_data_a, f);
    chk("mdl.occupancy", occ_a, m_q.size());
    chk("mdl.in_ready", in_ready_a, m_rdy);
    chk("mdl.flush_cnt", cnt_a, m_cnt8);
    chk("mdl2.out_valid", out_valid_b, v);
    chk("mdl2.out_data", out_data_b, v ? m_q[0] : BUB2);
    chk("mdl2.in_ready", in_ready_b, m_rdy);
    chk("mdl2.flush_cnt", cnt_b, m_cnt2);
  endtask

  task automatic step(input logic c, input logic iv, input logic [31:0] d,
                      input logic orr, input logic fl);
    clr = c; in_valid = iv; in_data = d; out_ready = orr; flush = fl;
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        c, iv;
    logic [31:0] d;
    logic        orr, fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        er;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, iv, input logic [31:0] d, input logic orr, fl,
                     input logic ev, input logic [31:0] ed, input logic [1:0] eo,
                     input logic er, input logic [7:0] ec);
    vec_t v;
    v.c = c; v.iv = iv; v.d = d; v.orr = orr; v.fl = fl;
    v.ev = ev; v.ed = ed; v.eo = eo; v.er = er; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    int sat_exp2[3];
    int sat_exp8[3];
    sat_exp2 = '{2, 3, 3};
    sat_exp8 = '{2, 4, 6};
    clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    //   clr iv data        ordy fl | vld data        occ rdy cnt
    add(0, 1, 32'h99,       1,   1,   0, 32'h0,       0,  1,  0);
    add(0, 0, 32'h0,        0,   0,   0, 32'h0,       0,  1,  0);
    add(1, 1, 32'h11,       1,   0,   1, 32'h11,      1,  1,  0);
    add(1, 1, 32'h22,       1,   0,   1, 32'h22,      1,  1,  0);
    add(1, 1, 32'h33,       1,   0,   1, 32'h33,      1,  1,  0);
    add(1, 0, 32'h0,        1,   0,   0, 32'h0,       0,  1,  0);
    add(1, 1, 32'hA0,       0,   0,   1, 32'hA0,      1,  1,  0);
    add(1, 1, 32'hA1,       0,   0,   1, 32'hA0,      2,  0,  0);
    add(1, 1, 32'hBB,       0,   0,   1, 32'hA0,      2,  0,  0);
    add(1, 0, 32'h0,        1,   0,   1, 32'hA1,      1,  1,  0);
    add(1, 0, 32'h0,        1,   0,   0, 32'h0,       0,  1,  0);
    add(1, 1, 32'hB0,       0,   0,   1, 32'hB0,      1,  1,  0);
    add(1, 1, 32'hB1,       0,   0,   1, 32'hB0,      2,  0,  0);
    add(1, 1, 32'hCC,       0,   1,   0, 32'h0,       0,  1,  2);
    add(1, 1, 32'h44,       0,   0,   1, 32'h44,      1,  1,  2);
    add(1, 1, 32'h55,       1,   1,   0, 32'h0,       0,  1,  3);
    add(1, 0, 32'h0,        1,   0,   0, 32'h0,       0,  1,  3);
    add(1, 1, 32'h66,       1,   1,   0, 32'h0,       0,  1,  4);
    add(1, 1, 32'h67,       1,   1,   0, 32'h0,       0,  1,  5);
    add(1, 0, 32'h0,        1,   1,   0, 32'h0,       0,  1,  5);
    add(1, 1, 32'hD0,       0,   0,   1, 32'hD0,      1,  1,  5);
    add(1, 1, 32'hD1,       0,   0,   1, 32'hD0,      2,  0,  5);
    add(0, 1, 32'hD2,       0,   1,   0, 32'h0,       0,  1,  0);
    add(1, 1, 32'h77,       0,   0,   1, 32'h77,      1,  1,  0);
    add(1, 0, 32'h0,        1,   0,   0, 32'h0,       0,  1,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].iv, tbl[i].d, tbl[i].orr, tbl[i].fl);
      chk($sformatf("tbl[%0d].out_valid", i), out_valid_a, tbl[i].ev);
      chk($sformatf("tbl[%0d].out_data", i), out_data_a, tbl[i].ed);
      chk($sformatf("tbl[%0d].occupancy", i), occ_a, tbl[i].eo);
      chk($sformatf("tbl[%0d].in_ready", i), in_ready_a, tbl[i].er);
      chk($sformatf("tbl[%0d].flush_cnt", i), cnt_a, tbl[i].ec);
    end

    // Repeated FULL flushes: 2-bit counter saturates at 3.
    step(0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 32'h100 + k, 0, 0);
      step(1, 1, 32'h200 + k, 0, 0);
      chk("full_before_flush.occupancy", occ_b, 2'd2);
      step(1, 1, 32'h300 + k, 0, 1);
      chk($sformatf("sat_cnt2[%0d]", k), cnt_b, sat_exp2[k]);
      chk($sformatf("sat_cnt8[%0d]", k), cnt_a, sat_exp8[k]);
      chk("after_flush.out_data2", out_data_b, BUB2);
    end

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 99) > 1, $urandom_range(0, 99) < 65, $urandom,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
